des_perm_pipe: RTL and testbench

DES_PERM_PIPE -- requirements
Module: des_perm_pipe

---
 rtl/des_perm_pipe.sv | 127 ++++++++++++
 tb/tb_des_perm_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_perm_pipe.sv
// DES initial / final bit permutation over LANES independent 64-bit blocks,
// followed by a PIPE-deep elastic register pipeline with valid/ready flow control.
module des_perm_pipe #(
  parameter int LANES = 1,
  parameter int PIPE  = 1,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic                  in_swap,
  input  logic [64*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [64*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic [31:0]           blk_cnt
);

  localparam int DW = 64 * LANES;

  // Vector bit 63 is DES bit 1, so DES bit n lives at vector index 64-n.
  // IP rows: 58,60,62,64,57,59,61,63 descending by 8 across the row.
  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    int          src;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      src = (((i / 8) < 4) ? (58 + 2 * (i / 8)) : (57 + 2 * ((i / 8) - 4))) - 8 * (i % 8);
      y[6'(63 - i)] = x[6'(64 - src)];
    end
    return y;
  endfunction

  // IP^-1 rows interleave 40-r+8k (even columns) with 8-r+8k (odd columns).
  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    int          src;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      src = (((i % 8) % 2 == 1) ? 8 : 40) - (i / 8) + 8 * ((i % 8) / 2);
      y[6'(63 - i)] = x[6'(64 - src)];
    end
    return y;
  endfunction

  logic [DW-1:0]    perm_p0;
  logic [63:0]      lane_p0;
  logic             vld_pn  [PIPE];
  logic [DW-1:0]    data_pn [PIPE];
  logic [TAG_W-1:0] tag_pn  [PIPE];
  logic             src_vld [PIPE];
  logic [DW-1:0]    src_data[PIPE];
  logic [TAG_W-1:0] src_tag [PIPE];
  logic [PIPE:0]    ld;
  logic [31:0]      cnt_q;

  // ---- stage 0: combinational swap + permutation ahead of the first register
  always_comb begin
    perm_p0 = '0;
    lane_p0 = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_p0 = in_data[64*k +: 64];
      if (in_swap) lane_p0 = {lane_p0[31:0], lane_p0[63:32]};
      perm_p0[64*k +: 64] = in_mode ? des_fp(lane_p0) : des_ip(lane_p0);
    end
  end

  // A stage may load when it is empty or its content moves on; ld[PIPE] is the sink.
  always_comb begin
    ld       = '0;
    ld[PIPE] = out_ready;
    for (int i = PIPE - 1; i >= 0; i--) begin
      ld[i] = ~vld_pn[i] | ld[i+1];
    end
  end

  always_comb begin
    src_vld[0]  = in_valid;
    src_data[0] = perm_p0;
    src_tag[0]  = in_tag;
    for (int i = 1; i < PIPE; i++) begin
      src_vld[i]  = vld_pn[i-1];
      src_data[i] = data_pn[i-1];
      src_tag[i]  = tag_pn[i-1];
    end
  end

  // ---- stages 1..PIPE: elastic registers; payload only moves with a valid beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE; i++) begin
        vld_pn[i]  <= 1'b0;
        data_pn[i] <= '0;
        tag_pn[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < PIPE; i++) begin
        if (ld[i]) begin
          vld_pn[i] <= src_vld[i];
          if (src_vld[i]) begin
            data_pn[i] <= src_data[i];
            tag_pn[i]  <= src_tag[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (in_valid && ld[0]) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld_pn[PIPE-1];
  assign out_data  = data_pn[PIPE-1];
  assign out_tag   = tag_pn[PIPE-1];
  assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Scoreboard bench for des_perm_pipe: driver queues expected beats on acceptance,
// a negedge monitor pops and compares every consumed output beat.
module tb_des_perm_pipe;

  localparam int LANES = 2;
  localparam int PIPE  = 3;
  localparam int TAG_W = 4;
  localparam int DW    = 64 * LANES;

  localparam int IP_T[64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                              62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                              57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
                              61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T[64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                              38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                              36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                              34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid, in_ready, in_mode, in_swap;
  logic [DW-1:0]    in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [DW-1:0]    out_data;
  logic [TAG_W-1:0] out_tag;
  logic [31:0]      blk_cnt;

  always #5 clk = ~clk;

  des_perm_pipe #(.LANES(LANES), .PIPE(PIPE), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_swap(in_swap),
    .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .blk_cnt(blk_cnt)
  );

  typedef struct packed {
    logic [DW-1:0]    d;
    logic [TAG_W-1:0] t;
  } beat_t;

  beat_t            exp_q[$];
  int               n_chk = 0;
  int               n_fail = 0;
  int               n_out = 0;
  logic             hold_v = 1'b0;
  logic [DW-1:0]    hold_d;
  logic [TAG_W-1:0] hold_t;
  logic             rnd_done;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] ref_perm(input logic [63:0] x, input logic mode, input logic swap);
    logic [63:0] s, y;
    s = swap ? {x[31:0], x[63:32]} : x;
    for (int j = 0; j < 64; j++)
      y[6'(63 - j)] = s[6'(64 - (mode ? FP_T[j] : IP_T[j]))];
    return y;
  endfunction

  function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] x, input logic mode, input logic swap);
    logic [DW-1:0] y;
    for (int k = 0; k < LANES; k++) y[64*k +: 64] = ref_perm(x[64*k +: 64], mode, swap);
    return y;
  endfunction

  // Monitor: compares consumed beats and checks hold-stability under backpressure.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_data", 128'(out_data), 128'(hold_d));
        chk("hold_tag", 128'(out_tag), 128'(hold_t));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 128'(out_tag), 128'hx);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 128'(out_data), 128'(e.d));
          chk("out_tag", 128'(out_tag), 128'(e.t));
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_t = out_tag;
    end
  end

  // Called in the phase just after a rising edge; returns in that same phase.
  task automatic send(input logic m, input logic sw, input logic [DW-1:0] d,
                      input logic [TAG_W-1:0] t, input logic [DW-1:0] e);
    int    w;
    logic  ok;
    beat_t b;
    w = 0;
    ok = 1'b0;
    in_valid = 1'b1; in_mode = m; in_swap = sw; in_data = d; in_tag = t;
    while (!ok && w < 1000) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else begin @(posedge clk); #1; w++; end
    end
    if (ok) begin
      b.d = e; b.t = t;
      exp_q.push_back(b);
      @(posedge clk); #1;
    end else begin
      chk("send_timeout", 128'(ok), 128'(1));
    end
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_mode  = 1'($urandom);
    in_swap  = 1'($urandom);
  endtask

  task automatic send_rand(input logic [TAG_W-1:0] t);
    logic [DW-1:0] d;
    logic          m, sw;
    d  = {$urandom, $urandom, $urandom, $urandom};
    m  = 1'($urandom);
    sw = 1'($urandom);
    send(m, sw, d, t, ref_beat(d, m, sw));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] snap;
    int            lat, seen, base;
    in_valid = 1'b0; in_mode = 1'b0; in_swap = 1'b0; in_data = '0; in_tag = '0;
    out_ready = 1'b1;
    rnd_done = 1'b0;

    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_out_tag", 128'(out_tag), 128'(0));
    chk("rst_blk_cnt", 128'(blk_cnt), 128'(0));
    #4 rst_n = 1'b1;

    // Directed vectors, first accepted on the first edge after release.
    send(1'b0, 1'b0, {64'h8000000000000000, 64'h0123456789ABCDEF}, 4'h1,
         {64'h0000000001000000, 64'hCC00CCFFF0AAF0AA});
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", 128'(lat), 128'(PIPE));
    send(1'b1, 1'b1, {64'h0000000000000001, 64'h434232340A4CD995}, 4'h2,
         {64'h0100000000000000, 64'h85E813540F0AB405});
    send(1'b1, 1'b0, {64'h8000000000000000, 64'hCC00CCFFF0AAF0AA}, 4'h3,
         {64'h0000000000000040, 64'h0123456789ABCDEF});
    send(1'b0, 1'b1, {64'hFFFFFFFFFFFFFFFF, 64'h0000000080000000}, 4'h4,
         {64'hFFFFFFFFFFFFFFFF, 64'h0000000001000000});
    send(1'b0, 1'b0, {64'h0000000000000000, 64'h0000000000000001}, 4'h5,
         {64'h0000000000000000, 64'h0000008000000000});
    send(1'b1, 1'b0, {64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001}, 4'h6,
         {64'hFFFFFFFFFFFFFFFF, 64'h0200000000000000});
    drain();

    // Backpressure: fill the pipe, stall 10 cycles, then release while accepting.
    out_ready = 1'b0;
    send(1'b0, 1'b0, {64'h0, 64'h0123456789ABCDEF}, 4'h8, {64'h0, 64'hCC00CCFFF0AAF0AA});
    send(1'b1, 1'b0, {64'h0, 64'hCC00CCFFF0AAF0AA}, 4'h9, {64'h0, 64'h0123456789ABCDEF});
    send(1'b0, 1'b0, {64'h1, 64'h8000000000000000}, 4'hA, {64'h0000008000000000, 64'h0000000001000000});
    @(negedge clk);
    snap = out_data;
    for (int c = 0; c < 10; c++) begin
      chk("stall_in_ready", 128'(in_ready), 128'(0));
      chk("stall_out_valid", 128'(out_valid), 128'(1));
      @(negedge clk);
    end
    chk("stall_data", 128'(out_data), 128'(snap));
    @(posedge clk); #1;
    out_ready = 1'b1;
    fork
      send(1'b1, 1'b0, {64'h0, 64'h1}, 4'hB, {64'h0, 64'h0200000000000000});
      begin
        @(negedge clk);
        chk("full_consume_in_ready", 128'(in_ready), 128'(1));
        for (int c = 0; c < 4; c++) begin
          chk("release_consecutive", 128'(out_valid), 128'(1));
          @(negedge clk);
        end
      end
    join
    drain();

    // Reset with beats in flight.
    out_ready = 1'b0;
    send_rand(4'hC);
    send_rand(4'hD);
    send_rand(4'hE);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 128'(out_valid), 128'(0));
    chk("async_rst_out_data", 128'(out_data), 128'(0));
    chk("async_rst_out_tag", 128'(out_tag), 128'(0));
    chk("async_rst_blk_cnt", 128'(blk_cnt), 128'(0));
    chk("async_rst_in_ready", 128'(in_ready), 128'(1));
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("stale_after_reset", 128'(seen), 128'(0));
    @(posedge clk); #1;

    // Random stream with random backpressure.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 100; i++) send_rand(4'(i));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_blk_cnt", 128'(blk_cnt), 128'(100));
    chk("stream_beats_out", 128'(n_out - base), 128'(100));

    // Counter wrap.
    force dut.cnt_q = 32'hFFFFFFFE;
    @(posedge clk); #1;
    release dut.cnt_q;
    chk("forced_blk_cnt", 128'(blk_cnt), 128'(32'hFFFFFFFE));
    send_rand(4'h1);
    send_rand(4'h2);
    send_rand(4'h3);
    drain();
    chk("wrap_blk_cnt", 128'(blk_cnt), 128'(32'h00000001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
